// File: rtl/rf_dbg_port_arbiter.sv
// Shares the register file write port and debug read port between writeback and
// an external debug requester that halts the pipeline before each access.
module rf_dbg_port_arbiter #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DRAIN_TMO = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_dst_i,
  input  logic [XLEN-1:0] wb_r_i,
  input  logic            dbg_req_i,
  input  logic            dbg_we_i,
  input  logic [4:0]      dbg_addr_i,
  input  logic [XLEN-1:0] dbg_wdata_i,
  output logic            dbg_ack_o,
  output logic            dbg_err_o,
  output logic [XLEN-1:0] dbg_rdata_o,
  output logic            halt_req_o,
  input  logic            halted_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic [4:0]      rf_raddr_o,
  input  logic [XLEN-1:0] rf_rdata_i
);

  localparam int unsigned TMO_W = $clog2(DRAIN_TMO);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ACC,
    S_RD,
    S_RSP
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [4:0]        addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    halt_req_o = 1'b0;
    dbg_ack_o  = 1'b0;
    dbg_err_o  = 1'b0;
    rf_raddr_o = '0;
    // Writeback owns the write port unless a debug write is granted below.
    rf_we_o    = wb_we_i & (wb_dst_i != 5'd0);
    rf_waddr_o = wb_dst_i;
    rf_wdata_o = wb_r_i;

    unique case (state_q)
      S_IDLE: begin
        if (dbg_req_i) begin
          we_d    = dbg_we_i;
          addr_d  = dbg_addr_i;
          wdata_d = dbg_wdata_i;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        halt_req_o = 1'b1;
        if (!dbg_req_i) begin
          state_d = S_IDLE;
        end else if (halted_i && !wb_we_i) begin
          state_d = S_ACC;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RSP;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      S_ACC: begin
        halt_req_o = 1'b1;
        if (we_q) begin
          // A concurrent writeback keeps the port; the debug write retries next cycle.
          if (!wb_we_i) begin
            rf_we_o    = (addr_q != 5'd0);
            rf_waddr_o = addr_q;
            rf_wdata_o = wdata_q;
            err_d      = 1'b0;
            rdata_d    = '0;
            state_d    = S_RSP;
          end
        end else begin
          rf_raddr_o = addr_q;
          state_d    = S_RD;
        end
      end
      S_RD: begin
        halt_req_o = 1'b1;
        rdata_d    = (addr_q == 5'd0) ? '0 : rf_rdata_i;
        err_d      = 1'b0;
        state_d    = S_RSP;
      end
      S_RSP: begin
        dbg_ack_o = 1'b1;
        dbg_err_o = err_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dbg_rdata_o = rdata_q;

endmodule

// File: tb/tb_rf_dbg_port_arbiter.sv
// Randomized and directed bench for rf_dbg_port_arbiter against a transaction-level
// model that keeps its own golden copy of the register file.
module tb_rf_dbg_port_arbiter;
  localparam int unsigned XLEN = 32;
  localparam int unsigned TMO  = 8;

  localparam int P_IDLE  = 0;
  localparam int P_DRAIN = 1;
  localparam int P_ACC   = 2;
  localparam int P_READ  = 3;
  localparam int P_RESP  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wb_we_i = 1'b0;
  logic [4:0]      wb_dst_i = '0;
  logic [XLEN-1:0] wb_r_i = '0;
  logic            dbg_req_i = 1'b0;
  logic            dbg_we_i = 1'b0;
  logic [4:0]      dbg_addr_i = '0;
  logic [XLEN-1:0] dbg_wdata_i = '0;
  logic            dbg_ack_o, dbg_err_o, halt_req_o, rf_we_o;
  logic [XLEN-1:0] dbg_rdata_o, rf_wdata_o;
  logic            halted_i = 1'b0;
  logic [4:0]      rf_waddr_o, rf_raddr_o;
  logic [XLEN-1:0] rf_rdata_i = '0;

  rf_dbg_port_arbiter #(.XLEN(XLEN), .DRAIN_TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .wb_we_i(wb_we_i), .wb_dst_i(wb_dst_i), .wb_r_i(wb_r_i),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_err_o(dbg_err_o),
    .dbg_rdata_o(dbg_rdata_o), .halt_req_o(halt_req_o), .halted_i(halted_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i)
  );

  always #5 clk = ~clk;

  // Register file driven by the DUT, with one-cycle read latency.
  logic [XLEN-1:0] rf_mem [32] = '{default: '0};
  always @(posedge clk) begin
    if (rf_we_o) rf_mem[rf_waddr_o] <= rf_wdata_o;
    rf_rdata_i <= rf_mem[rf_raddr_o];
  end

  int n_pass = 0;
  int n_total = 0;
  logic chk_en = 1'b0;

  function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endfunction

  // Transaction-level model
  int              m_ph = P_IDLE;
  logic            m_we = 1'b0;
  logic [4:0]      m_addr = '0;
  logic [XLEN-1:0] m_wdata = '0;
  logic            m_err = 1'b0;
  logic [XLEN-1:0] m_rdata = '0;
  logic [XLEN-1:0] m_rd = '0;
  int              m_drain = 0;
  logic [XLEN-1:0] gold [32] = '{default: '0};

  always @(negedge clk) begin
    logic e_ack, e_halt, e_we, wb_path;
    logic [4:0] e_waddr;
    logic [XLEN-1:0] e_wdata;
    e_ack = 1'b0; e_halt = 1'b0; wb_path = 1'b1;
    e_halt = (m_ph == P_DRAIN) || (m_ph == P_ACC) || (m_ph == P_READ);
    e_ack  = (m_ph == P_RESP);
    if (m_ph == P_ACC && m_we && !wb_we_i) wb_path = 1'b0;
    e_we    = wb_path ? (wb_we_i && wb_dst_i != 5'd0) : (m_addr != 5'd0);
    e_waddr = wb_path ? wb_dst_i : m_addr;
    e_wdata = wb_path ? wb_r_i : m_wdata;

    if (chk_en) begin
      check("ack", dbg_ack_o, e_ack);
      check("halt_req", halt_req_o, e_halt);
      check("rdata", dbg_rdata_o, m_rdata);
      check("rf_we", rf_we_o, e_we);
      if (e_ack) check("err", dbg_err_o, m_err);
      if (e_we) begin
        check("rf_waddr", rf_waddr_o, e_waddr);
        check("rf_wdata", rf_wdata_o, e_wdata);
      end
      if (m_ph == P_ACC && !m_we) check("rf_raddr", rf_raddr_o, m_addr);
    end

    if (m_ph == P_ACC && !m_we) m_rd = (m_addr == 5'd0) ? '0 : gold[m_addr];
    if (e_we) gold[e_waddr] = e_wdata;

    if (rst) begin
      m_ph = P_IDLE; m_rdata = '0; m_err = 1'b0;
    end else begin
      case (m_ph)
        P_IDLE: if (dbg_req_i) begin
          m_we = dbg_we_i; m_addr = dbg_addr_i; m_wdata = dbg_wdata_i;
          m_drain = 0; m_ph = P_DRAIN;
        end
        P_DRAIN: begin
          if (!dbg_req_i) m_ph = P_IDLE;
          else if (halted_i && !wb_we_i) m_ph = P_ACC;
          else if (m_drain == TMO - 1) begin m_ph = P_RESP; m_err = 1'b1; m_rdata = '0; end
          else m_drain++;
        end
        P_ACC: begin
          if (!m_we) m_ph = P_READ;
          else if (!wb_we_i) begin m_ph = P_RESP; m_err = 1'b0; m_rdata = '0; end
        end
        P_READ: begin m_ph = P_RESP; m_err = 1'b0; m_rdata = m_rd; end
        default: m_ph = P_IDLE;
      endcase
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input logic we, input logic [4:0] a, input logic [31:0] wd,
                         input int maxc, output int lat, output int wcyc,
                         output logic err, output logic [31:0] rd);
    logic got;
    got = 1'b0; err = 1'b0; rd = '0; lat = 0; wcyc = -1;
    dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = wd;
    while (1) begin
      @(negedge clk);
      if (rf_we_o && wcyc < 0) wcyc = lat;
      if (dbg_ack_o) begin got = 1'b1; err = dbg_err_o; rd = dbg_rdata_o; break; end
      if (lat >= maxc) break;
      next_cyc();
      lat++;
    end
    next_cyc();
    dbg_req_i = 1'b0;
    if (!got) begin
      n_total++;
      $display("FAIL ack_bound: no ack after %0d cycles, required ack", lat);
    end
  endtask

  task automatic rand_wb(input int pct);
    wb_we_i  = ($urandom_range(0, 99) < pct);
    wb_dst_i = 5'($urandom_range(0, 31));
    wb_r_i   = $urandom;
  endtask

  initial begin
    int lat, wcyc;
    logic err;
    logic [31:0] rd;

    repeat (3) next_cyc();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_ack", dbg_ack_o, 0);
    check("rst_halt", halt_req_o, 0);
    check("rst_rdata", dbg_rdata_o, 0);
    check("rst_rf_we", rf_we_o, 0);
    next_cyc();
    rst = 1'b0;
    halted_i = 1'b1;
    next_cyc();

    // T1: write x5 then read it back
    run_req(1'b1, 5'd5, 32'hDEADBEEF, 20, lat, wcyc, err, rd);
    check("t1_lat", lat, 3);
    check("t1_we_cycle", wcyc, 2);
    check("t1_err", err, 0);
    run_req(1'b0, 5'd5, 32'h0, 20, lat, wcyc, err, rd);
    check("t1_rb_lat", lat, 4);
    check("t1_rb_data", rd, 32'hDEADBEEF);

    // T2: preload x7 via writeback, then debug read
    wb_we_i = 1'b1; wb_dst_i = 5'd7; wb_r_i = 32'h1234;
    next_cyc();
    wb_we_i = 1'b0;
    run_req(1'b0, 5'd7, 32'h0, 20, lat, wcyc, err, rd);
    check("t2_lat", lat, 4);
    check("t2_data", rd, 32'h1234);
    check("t2_err", err, 0);

    // T3: write to x0 is dropped
    run_req(1'b1, 5'd0, 32'hFFFFFFFF, 20, lat, wcyc, err, rd);
    check("t3_lat", lat, 3);
    check("t3_no_we", wcyc, 32'hFFFFFFFF);
    run_req(1'b0, 5'd0, 32'h0, 20, lat, wcyc, err, rd);
    check("t3_x0_data", rd, 0);

    // T4: drain timeout
    halted_i = 1'b0;
    run_req(1'b1, 5'd9, 32'hCAFEF00D, 30, lat, wcyc, err, rd);
    check("t4_lat", lat, 9);
    check("t4_err", err, 1);
    check("t4_rdata", rd, 0);
    check("t4_no_we", wcyc, 32'hFFFFFFFF);
    check("t4_x9", rf_mem[9], 0);
    halted_i = 1'b1;

    // T5: writeback collides with the debug write in ACC
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd3; dbg_wdata_i = 32'hAA;
    next_cyc();
    next_cyc();
    wb_we_i = 1'b1; wb_dst_i = 5'd3; wb_r_i = 32'h55;
    @(negedge clk);
    check("t5_wb_we", rf_we_o, 1);
    check("t5_wb_data", rf_wdata_o, 32'h55);
    check("t5_no_ack", dbg_ack_o, 0);
    next_cyc();
    wb_we_i = 1'b0;
    @(negedge clk);
    check("t5_dbg_we", rf_we_o, 1);
    check("t5_dbg_data", rf_wdata_o, 32'hAA);
    next_cyc();
    @(negedge clk);
    check("t5_ack", dbg_ack_o, 1);
    next_cyc();
    dbg_req_i = 1'b0;
    next_cyc();
    check("t5_x3", rf_mem[3], 32'hAA);

    // T6a: reset during HALT
    halted_i = 1'b0;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd4;
    next_cyc();
    @(negedge clk);
    check("t6a_halt", halt_req_o, 1);
    next_cyc();
    rst = 1'b1; dbg_req_i = 1'b0;
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    check("t6a_halt_clr", halt_req_o, 0);
    check("t6a_no_ack", dbg_ack_o, 0);
    repeat (3) next_cyc();

    // T6b: request withdrawn during HALT
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd6; dbg_wdata_i = 32'h77;
    next_cyc();
    next_cyc();
    dbg_req_i = 1'b0;
    @(negedge clk);
    check("t6b_halt", halt_req_o, 1);
    next_cyc();
    @(negedge clk);
    check("t6b_halt_clr", halt_req_o, 0);
    check("t6b_no_ack", dbg_ack_o, 0);
    next_cyc();
    halted_i = 1'b1;

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      logic acked, dropped, drop_en;
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        rand_wb(50);
        halted_i = $urandom_range(0, 1);
        next_cyc();
      end
      acked = 1'b0; dropped = 1'b0;
      drop_en = ($urandom_range(0, 7) == 0);
      dbg_req_i   = 1'b1;
      dbg_we_i    = $urandom_range(0, 1);
      dbg_addr_i  = 5'($urandom_range(0, 7));
      dbg_wdata_i = $urandom;
      for (int c = 0; c < 200; c++) begin
        rand_wb(25);
        halted_i = ($urandom_range(0, 2) == 0);
        if (drop_en && m_ph == P_DRAIN && $urandom_range(0, 2) == 0) begin
          dbg_req_i = 1'b0;
          dropped = 1'b1;
        end
        @(negedge clk);
        if (dbg_ack_o) acked = 1'b1;
        next_cyc();
        if (acked || dropped) break;
      end
      dbg_req_i = 1'b0;
      wb_we_i = 1'b0;
      if (!acked && !dropped) begin
        n_total++;
        $display("FAIL rand_ack_bound: txn %0d got no ack, required ack", t);
      end
    end
    repeat (2) next_cyc();

    for (int i = 0; i < 32; i++) check($sformatf("rf_final_x%0d", i), rf_mem[i], gold[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
